// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

  localparam int ADDR_W_DEFAULT = 30;
  localparam int JUMP_W         = 26;
  localparam int IMM_W          = 16;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Widened to 64 bits so callers can slice down to any address width.
  function automatic logic [63:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(64 - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-PC selection: jump, taken branch or increment.
// Out-of-range flag is present only when FETCH_BOUNDS_CHECK_EN is defined.
module next_pc_calc
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DEPTH  = 1024
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump,
  input  logic [JUMP_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [IMM_W-1:0]  branch_imm,
  output logic [ADDR_W-1:0] next_pc
`ifdef FETCH_BOUNDS_CHECK_EN
  ,
  output logic              out_of_range
`endif
);

  logic [63:0]       imm_wide;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] seq_pc;

  assign imm_wide = sext_imm(branch_imm);
  assign imm_ext  = imm_wide[ADDR_W-1:0];
  assign seq_pc   = pc + ADDR_W'(1);

  // Jump outranks a taken branch; all arithmetic wraps at 2^ADDR_W.
  always_comb begin
    next_pc = seq_pc;
    if (jump) begin
      next_pc = {pc[ADDR_W-1:JUMP_W], jump_target};
    end else if (branch_taken) begin
      next_pc = seq_pc + imm_ext;
    end
  end

`ifdef FETCH_BOUNDS_CHECK_EN
  assign out_of_range = {1'b0, next_pc} >= (ADDR_W + 1)'(DEPTH);
`endif

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller owning the instruction memory port; hands it to a loader on request.
// Optional fetch/load bounds checking with FAULT state: FETCH_BOUNDS_CHECK_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEFAULT,
  parameter int              DEPTH    = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              jump,
  input  logic [JUMP_W-1:0] jumpTarget,
  input  logic              branch,
  input  logic              zero,
  input  logic [IMM_W-1:0]  branchImm,
  input  logic              loadReq,
  input  logic              loadValid,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [31:0]       loadData,
  output logic              loadReady,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWE,
  output logic [31:0]       memDataIn,
  output logic [ADDR_W-1:0] pc,
  output logic              instrValid,
  output logic              fault
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] calc_pc;
  logic              load_in_range;
  logic              in_load;

`ifdef FETCH_BOUNDS_CHECK_EN
  logic out_of_range;
`endif

  next_pc_calc #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_next_pc (
    .pc          (pc_reg),
    .jump        (jump),
    .jump_target (jumpTarget),
    .branch_taken(branch && zero),
    .branch_imm  (branchImm),
    .next_pc     (calc_pc)
`ifdef FETCH_BOUNDS_CHECK_EN
    ,
    .out_of_range(out_of_range)
`endif
  );

`ifdef FETCH_BOUNDS_CHECK_EN
  assign load_in_range = {1'b0, loadAddr} < (ADDR_W + 1)'(DEPTH);
  assign fault         = (state_reg == FAULT);
`else
  assign load_in_range = 1'b1;
  assign fault         = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      BOOT: begin
        pc_next    = RESET_PC;
        state_next = loadReq ? LOAD : RUN;
      end
      RUN: begin
        if (loadReq) begin
          state_next = LOAD;
        end else if (!stall) begin
`ifdef FETCH_BOUNDS_CHECK_EN
          // An illegal target parks the PC at its last legal value.
          if (out_of_range) state_next = FAULT;
          else              pc_next    = calc_pc;
`else
          pc_next = calc_pc;
`endif
        end
      end
      LOAD: begin
        if (!loadReq) begin
          state_next = BOOT;
          pc_next    = RESET_PC;
        end
      end
`ifdef FETCH_BOUNDS_CHECK_EN
      FAULT: begin
        if (loadReq) state_next = LOAD;
      end
`endif
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  assign in_load    = (state_reg == LOAD);
  assign pc         = pc_reg;
  assign loadReady  = in_load;
  assign instrValid = (state_reg == RUN) && !stall;
  assign memAddr    = in_load ? loadAddr : pc_reg;
  assign memWE      = in_load && loadValid && load_in_range;
  assign memDataIn  = in_load ? loadData : 32'd0;

endmodule
